// File: rtl/tile_sweep_pkg.sv
// Shared types for the tile sweep read sequencer: FSM states, sweep order
// encodings, the control half of the delay-line tag and a width helper.
package tile_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    WAIT
  } sweep_state_t;

  typedef enum logic {
    ORD_PLANAR,
    ORD_INTERLEAVED
  } sweep_order_t;

  // Control flags of a delay-line tag. The coordinate fields are appended by
  // the user of this type with widths that depend on the tile geometry.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_ctrl_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_sweep_tagpipe.sv
// RD_LAT-deep shift register that carries valid/last and the row/col/chan
// coordinates of each issued read so they line up with the returned data.
module tile_sweep_tagpipe
  import tile_sweep_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int ROW_W  = 3,
  parameter int COL_W  = 3,
  parameter int CHA_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [ROW_W-1:0] in_row,
  input  logic [COL_W-1:0] in_col,
  input  logic [CHA_W-1:0] in_cha,
  output logic             out_valid,
  output logic             out_last,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic [CHA_W-1:0] out_cha
);

  typedef struct packed {
    tag_ctrl_t        ctrl;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [CHA_W-1:0] cha;
  } tag_t;

  tag_t in_tag;
  tag_t stage [RD_LAT];

  assign in_tag = {in_valid, in_last, in_row, in_col, in_cha};

  // Shift every cycle regardless of hold; reset flushes all stages so no
  // stale valid can emerge after an aborted sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= in_tag;
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_valid = stage[RD_LAT-1].ctrl.valid;
  assign out_last  = stage[RD_LAT-1].ctrl.last;
  assign out_row   = stage[RD_LAT-1].row;
  assign out_col   = stage[RD_LAT-1].col;
  assign out_cha   = stage[RD_LAT-1].cha;

endmodule

// File: rtl/tile_sweep_ctrl.sv
// Read sequencer for a multi-channel tile buffer. A start pulse sweeps every
// word once in planar or interleaved order, tags are delayed by the memory
// read latency, and data_rdy is held until the consumer returns data_done.
// Optional macro TILE_SWEEP_PERF_EN adds a saturating READ+DRAIN cycle
// counter on perf_cycles; without it perf_cycles is tied to zero.
module tile_sweep_ctrl
  import tile_sweep_pkg::*;
#(
  parameter  int ROWS   = 8,
  parameter  int COLS   = 8,
  parameter  int CHANS  = 3,
  parameter  int RD_LAT = 2,
  parameter  int ADDR_W = 8,
  localparam int ROW_W  = width_of(ROWS),
  localparam int COL_W  = width_of(COLS),
  localparam int CHA_W  = width_of(CHANS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              order,
  input  logic              hold,
  input  logic              data_done,
  output logic              busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              rd_valid,
  output logic              rd_last,
  output logic [ROW_W-1:0]  row_addr,
  output logic [COL_W-1:0]  col_addr,
  output logic [CHA_W-1:0]  cha_addr,
  output logic              data_rdy,
  output logic [15:0]       perf_cycles
);

  localparam int NWORDS = ROWS * COLS * CHANS;
  localparam int PLANE  = ROWS * COLS;
  localparam int DRN_W  = width_of(RD_LAT);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [CHA_W-1:0] CHA_MAX = CHA_W'(CHANS - 1);

  if (NWORDS > (2 ** ADDR_W)) begin : g_addr_too_narrow
    $error("tile_sweep_ctrl: ROWS*COLS*CHANS does not fit in ADDR_W bits");
  end

  sweep_state_t     state;
  sweep_order_t     order_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [CHA_W-1:0] cha_q;
  logic [DRN_W-1:0] drain_q;
  logic             final_word;

  // Every order ends on the word with all three coordinates at their maximum.
  assign final_word = (row_q == ROW_MAX) && (col_q == COL_MAX) && (cha_q == CHA_MAX);
  assign mem_en     = (state == READ) && !hold;
  assign mem_addr   = ADDR_W'(32'(cha_q) * 32'(PLANE) + 32'(row_q) * 32'(COLS) + 32'(col_q));

  // Sweep FSM: owns the coordinate counters, drain timer and handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      order_q  <= ORD_PLANAR;
      row_q    <= '0;
      col_q    <= '0;
      cha_q    <= '0;
      drain_q  <= '0;
      busy     <= 1'b0;
      data_rdy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            order_q <= sweep_order_t'(order);
            row_q   <= '0;
            col_q   <= '0;
            cha_q   <= '0;
            busy    <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          if (mem_en) begin
            if (final_word) begin
              row_q   <= '0;
              col_q   <= '0;
              cha_q   <= '0;
              drain_q <= DRN_W'(RD_LAT - 1);
              state   <= DRAIN;
            end else if (order_q == ORD_PLANAR) begin
              if (col_q == COL_MAX) begin
                col_q <= '0;
                if (row_q == ROW_MAX) begin
                  row_q <= '0;
                  cha_q <= cha_q + 1'b1;
                end else begin
                  row_q <= row_q + 1'b1;
                end
              end else begin
                col_q <= col_q + 1'b1;
              end
            end else begin
              if (cha_q == CHA_MAX) begin
                cha_q <= '0;
                if (col_q == COL_MAX) begin
                  col_q <= '0;
                  row_q <= row_q + 1'b1;
                end else begin
                  col_q <= col_q + 1'b1;
                end
              end else begin
                cha_q <= cha_q + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            data_rdy <= 1'b1;
            state    <= WAIT;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        WAIT: begin
          if (data_done) begin
            data_rdy <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tile_sweep_tagpipe #(
    .RD_LAT (RD_LAT),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W),
    .CHA_W  (CHA_W)
  ) u_tagpipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mem_en),
    .in_last   (mem_en && final_word),
    .in_row    (row_q),
    .in_col    (col_q),
    .in_cha    (cha_q),
    .out_valid (rd_valid),
    .out_last  (rd_last),
    .out_row   (row_addr),
    .out_col   (col_addr),
    .out_cha   (cha_addr)
  );

`ifdef TILE_SWEEP_PERF_EN
  logic [15:0] perf_q;

  // Count READ and DRAIN cycles of the current sweep, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if ((state == IDLE) && start) begin
      perf_q <= '0;
    end else if (((state == READ) || (state == DRAIN)) && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_tile_sweep_ctrl.sv
// Randomised scoreboard bench for tile_sweep_ctrl. Sweeps are modelled as
// plain nested loops over the tile; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_tile_sweep_ctrl;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int CHANS  = 3;
  localparam int RD_LAT = 2;
  localparam int ADDR_W = 8;
  localparam int NWORDS = ROWS * COLS * CHANS;
  localparam int ROW_W  = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int COL_W  = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int CHA_W  = (CHANS > 1) ? $clog2(CHANS) : 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              order = 1'b0;
  logic              hold = 1'b0;
  logic              data_done = 1'b0;
  logic              busy;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              rd_valid;
  logic              rd_last;
  logic [ROW_W-1:0]  row_addr;
  logic [COL_W-1:0]  col_addr;
  logic [CHA_W-1:0]  cha_addr;
  logic              data_rdy;
  logic [15:0]       perf_cycles;

  tile_sweep_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .CHANS(CHANS), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .order(order), .hold(hold),
    .data_done(data_done), .busy(busy), .mem_en(mem_en), .mem_addr(mem_addr),
    .rd_valid(rd_valid), .rd_last(rd_last), .row_addr(row_addr),
    .col_addr(col_addr), .cha_addr(cha_addr), .data_rdy(data_rdy),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int row;
    int col;
    int cha;
    bit last;
  } word_t;

  word_t addr_q[$];
  word_t tag_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rdy_due = 0;
  int perf_exp = 0;
  bit armed = 1'b0;
  bit issue_live = 1'b0;
  bit exp_hist [RD_LAT];
  bit exp_en;
  word_t mw;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: event seen, none expected at cycle %0d", name, cyc);
  endtask

  function automatic word_t makeWord(input int r, input int c, input int ch, input int n);
    word_t w;
    w.addr = ch * ROWS * COLS + r * COLS + c;
    w.row  = r;
    w.col  = c;
    w.cha  = ch;
    w.last = (n == NWORDS - 1);
    return w;
  endfunction

  // Reference order of a sweep, straight from the tile traversal rules.
  task automatic buildSweep(input bit ord);
    int n;
    word_t w;
    n = 0;
    if (!ord) begin
      for (int ch = 0; ch < CHANS; ch++)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) begin
            w = makeWord(r, c, ch, n++);
            addr_q.push_back(w);
            tag_q.push_back(w);
          end
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          for (int ch = 0; ch < CHANS; ch++) begin
            w = makeWord(r, c, ch, n++);
            addr_q.push_back(w);
            tag_q.push_back(w);
          end
    end
  endtask

  // Monitor: compares issue side, delayed tags and handshake timing.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      addr_q.delete();
      tag_q.delete();
      issue_live = 1'b0;
      armed = 1'b0;
      rdy_due = 0;
      for (int i = 0; i < RD_LAT; i++) exp_hist[i] = 1'b0;
    end else begin
      if (rdy_due > 0) begin
        rdy_due--;
        if (rdy_due == 0) begin
          checkOutput("data_rdy_rise", data_rdy, 1);
`ifdef TILE_SWEEP_PERF_EN
          perf_exp = cyc - start_cyc - 1;
`else
          perf_exp = 0;
`endif
          checkOutput("perf_cycles_wait", perf_cycles, perf_exp);
        end else begin
          checkOutput("data_rdy_early", data_rdy, 0);
        end
      end

      exp_en = issue_live && !hold;
      checkOutput("mem_en", mem_en, exp_en);
      if (mem_en) begin
        if (addr_q.size() == 0) failNow("mem_en_extra");
        else begin
          mw = addr_q.pop_front();
          checkOutput("mem_addr", mem_addr, mw.addr);
          if (mw.last) begin
            issue_live = 1'b0;
            rdy_due = RD_LAT + 1;
          end
        end
      end

      checkOutput("rd_valid", rd_valid, exp_hist[RD_LAT-1]);
      if (rd_valid) begin
        if (tag_q.size() == 0) failNow("rd_valid_extra");
        else begin
          mw = tag_q.pop_front();
          checkOutput("row_addr", row_addr, mw.row);
          checkOutput("col_addr", col_addr, mw.col);
          checkOutput("cha_addr", cha_addr, mw.cha);
          checkOutput("rd_last", rd_last, mw.last);
        end
      end else begin
        checkOutput("rd_last_idle", rd_last, 0);
      end
      for (int i = RD_LAT - 1; i > 0; i--) exp_hist[i] = exp_hist[i-1];
      exp_hist[0] = exp_en;

      if (start && armed) begin
        armed = 1'b0;
        start_cyc = cyc;
        issue_live = 1'b1;
      end
    end
  end

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic doReset();
    reset = 1'b1;
    hold = 1'b0;
    start = 1'b0;
    data_done = 1'b0;
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_mem_en", mem_en, 0);
    checkOutput("reset_rd_valid", rd_valid, 0);
    checkOutput("reset_data_rdy", data_rdy, 0);
    checkOutput("reset_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    perf_exp = 0;
  endtask

  // One sweep: start, optional holds/noise, then acknowledge after a delay.
  task automatic applyStimulus(input bit ord, input int hold_pct, input bit hold_final,
                               input bit noise, input int abort_after);
    int guard;
    int final_holds;
    int ack_delay;
    @(posedge clk); #1;
    checkOutput("idle_before_start", busy, 0);
    start = 1'b1;
    order = ord;
    buildSweep(ord);
    armed = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    order = 1'($urandom);
    guard = 0;
    final_holds = 0;
    while (!data_rdy && guard < 4 * NWORDS) begin
      if (abort_after > 0 && guard == abort_after) begin
        doReset();
        return;
      end
      hold = (hold_pct > 0) && ($urandom_range(99) < hold_pct);
      if (hold_final && addr_q.size() == 1 && final_holds < 3) begin
        hold = 1'b1;
        final_holds++;
      end
      if (noise) begin
        start = ($urandom_range(15) == 0);
        data_done = ($urandom_range(15) == 0);
      end
      @(posedge clk); #1;
      guard++;
    end
    hold = 1'b0;
    start = 1'b0;
    data_done = 1'b0;
    if (!data_rdy) begin
      failNow("data_rdy_timeout");
      return;
    end
    ack_delay = $urandom_range(4);
    repeat (ack_delay) begin
      @(posedge clk); #1;
      checkOutput("data_rdy_held", data_rdy, 1);
      checkOutput("busy_in_wait", busy, 1);
    end
    data_done = 1'b1;
    @(posedge clk); #1;
    data_done = 1'b0;
    checkOutput("busy_after_done", busy, 0);
    checkOutput("data_rdy_after_done", data_rdy, 0);
    checkOutput("perf_cycles_idle", perf_cycles, perf_exp);
    checkOutput("addr_outstanding", addr_q.size(), 0);
    checkOutput("tags_outstanding", tag_q.size(), 0);
  endtask

  initial begin
    #3;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_rd_last", rd_last, 0);
    checkOutput("rst_data_rdy", data_rdy, 0);
    checkOutput("rst_perf", perf_cycles, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    applyStimulus(1'b0, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 10, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 15, 1'b1, 1'b1, 0);
    applyStimulus(1'b0, 5, 1'b0, 1'b1, 50);
    applyStimulus(1'($urandom), 20, 1'b1, 1'b1, 0);
    applyStimulus(1'($urandom), 0, 1'b0, 1'b1, 0);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("final_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
